// File: rtl/y86_pkg.sv
// y86_pkg
// Shared definitions for the Y86 fetch front end.
//   pf_state_t      : prefetch request state machine (IDLE / REQ / DROP)
//   MAX_INST_BYTES  : longest Y86 instruction, in bytes
//   I_*             : instruction icode values used by fetch and control
//   inst_length()   : encoded length of an instruction given its icode
package y86_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } pf_state_t;

   localparam int unsigned MAX_INST_BYTES = 10;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   function automatic logic [3:0] inst_length(input logic [3:0] icode);
      logic [3:0] len;
      case (icode)
         I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: len = 4'd2;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     len = 4'd10;
         I_JXX, I_CALL:                    len = 4'd9;
         default:                          len = 4'd1;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/imem_prefetch_buffer_byte_ring.sv
// byte_ring
// Circular byte store for the instruction prefetch queue.
//   clk, reset : clock, asynchronous active-high reset (clears storage)
//   wr_en      : write strobe for the 8-byte port
//   wr_ptr     : ring index of wr_data[7:0]
//   wr_mask    : per-byte enable; byte i lands at wr_ptr+i (mod DEPTH)
//   wr_data    : up to 8 bytes, little-endian
//   rd_ptr     : ring index of rd_data[7:0]
//   rd_data    : MAX_INST_BYTES bytes starting at rd_ptr, wrapping
module byte_ring
   import y86_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned PW    = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [PW-1:0]                 wr_ptr,
   input  logic [7:0]                    wr_mask,
   input  logic [63:0]                   wr_data,
   input  logic [PW-1:0]                 rd_ptr,
   output logic [8*MAX_INST_BYTES-1:0]   rd_data
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[PW'(i)] <= '0;
         end
      end else if (wr_en) begin
         for (int unsigned i = 0; i < 8; i++) begin
            if (wr_mask[i]) begin
               mem[wr_ptr + PW'(i)] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   // Pointer arithmetic is PW bits wide, so rd_ptr+i wraps around the ring.
   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < MAX_INST_BYTES; i++) begin
         rd_data[8*i +: 8] = mem[rd_ptr + PW'(i)];
      end
   end

endmodule

// File: rtl/imem_prefetch_buffer.sv
// imem_prefetch_buffer
// Instruction prefetch queue in front of the Y86 fetch stage. Streams aligned
// 8-byte words from instruction memory into a byte ring and presents the next
// MAX_INST_BYTES bytes at head_pc.
//   clk, reset             : clock, asynchronous active-high reset
//   redirect, redirect_pc  : flush the queue and restart at redirect_pc
//   consume, consume_len   : fetch accepted an instruction of 1..10 bytes
//   inst_valid             : inst_bytes usable, or a memory error is pending
//   inst_bytes             : bytes at head_pc, [7:0] = byte at head_pc
//   head_pc                : address of inst_bytes[7:0]
//   imem_error             : a memory error has reached the queue head
//   mem_req, mem_addr      : word read request, 8-byte aligned address
//   mem_ack, mem_rdata     : one-cycle response strobe and word data
//   mem_err                : qualifies mem_ack; the returned word is invalid
module imem_prefetch_buffer
   import y86_pkg::*;
#(
   parameter int unsigned BUF_BYTES = 32,
   parameter int unsigned ADDR_W    = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          redirect,
   input  logic [ADDR_W-1:0]             redirect_pc,
   input  logic                          consume,
   input  logic [3:0]                    consume_len,
   output logic                          inst_valid,
   output logic [8*MAX_INST_BYTES-1:0]   inst_bytes,
   output logic [ADDR_W-1:0]             head_pc,
   output logic                          imem_error,
   output logic                          mem_req,
   output logic [ADDR_W-1:0]             mem_addr,
   input  logic                          mem_ack,
   input  logic [63:0]                   mem_rdata,
   input  logic                          mem_err
);

   localparam int unsigned   PW         = $clog2(BUF_BYTES);
   localparam int unsigned   CW         = PW + 1;
   localparam logic [CW-1:0] FILL_LIMIT = CW'(BUF_BYTES - 8);
   localparam logic [CW-1:0] MIN_COUNT  = CW'(MAX_INST_BYTES);

   pf_state_t         state;
   logic [CW-1:0]     count;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [ADDR_W-1:0] fill_addr;
   logic [2:0]        skip;
   logic              err_pend;

   logic              do_fill;
   logic              do_consume;
   logic [3:0]        fill_bytes;
   logic [CW-1:0]     count_next;
   logic [63:0]       wr_data;
   logic [7:0]        wr_mask;

   always_comb begin
      imem_error = err_pend && (count < MIN_COUNT);
      inst_valid = (count >= MIN_COUNT) || imem_error;
   end

   // The first word after a redirect may start mid-word: the leading skip
   // bytes are shifted out and only 8-skip bytes are written.
   always_comb begin
      fill_bytes = 4'd8 - {1'b0, skip};
      wr_data    = mem_rdata >> {skip, 3'b000};
      wr_mask    = 8'hFF >> skip;
      do_fill    = (state == S_REQ) && mem_ack && !mem_err && !redirect;
      do_consume = consume && inst_valid && !imem_error &&
                   (consume_len != 4'd0) && (CW'(consume_len) <= count);
      count_next = count
                 - (do_consume ? CW'(consume_len) : '0)
                 + (do_fill    ? CW'(fill_bytes)  : '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         count     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         head_pc   <= '0;
         fill_addr <= '0;
         skip      <= '0;
         err_pend  <= 1'b0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
      end else if (redirect) begin
         count     <= '0;
         rd_ptr    <= wr_ptr;
         head_pc   <= redirect_pc;
         err_pend  <= 1'b0;
         fill_addr <= {redirect_pc[ADDR_W-1:3], 3'b000};
         skip      <= redirect_pc[2:0];
         // An in-flight request cannot be withdrawn; DROP absorbs its ack.
         // A DROP ack landing in the redirect cycle still completes it, or
         // the machine would wait for an ack that never comes.
         case (state)
            S_REQ: begin
               if (mem_ack) begin
                  state   <= S_IDLE;
                  mem_req <= 1'b0;
               end else begin
                  state   <= S_DROP;
               end
            end
            S_DROP: begin
               if (mem_ack) begin
                  state   <= S_IDLE;
                  mem_req <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end else begin
         count <= count_next;
         if (do_consume) begin
            rd_ptr  <= rd_ptr + PW'(consume_len);
            head_pc <= head_pc + ADDR_W'(consume_len);
         end
         if (do_fill) begin
            wr_ptr    <= wr_ptr + PW'(fill_bytes);
            fill_addr <= fill_addr + ADDR_W'(8);
            skip      <= '0;
         end
         case (state)
            S_IDLE: begin
               if (!err_pend && (count <= FILL_LIMIT)) begin
                  state    <= S_REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= fill_addr;
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  state   <= S_IDLE;
                  mem_req <= 1'b0;
                  if (mem_err) begin
                     err_pend <= 1'b1;
                  end
               end
            end
            S_DROP: begin
               if (mem_ack) begin
                  state   <= S_IDLE;
                  mem_req <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   byte_ring #(
      .DEPTH (BUF_BYTES),
      .PW    (PW)
   ) u_ring (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (do_fill),
      .wr_ptr  (wr_ptr),
      .wr_mask (wr_mask),
      .wr_data (wr_data),
      .rd_ptr  (rd_ptr),
      .rd_data (inst_bytes)
   );

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// tb_imem_prefetch_buffer
// Randomized bench for imem_prefetch_buffer. A queue-of-bytes reference model
// tracks what fetch should see; a memory responder returns address-derived
// words with random latency and optional error injection.
module tb_imem_prefetch_buffer;
   import y86_pkg::*;

   localparam int unsigned BUF = 32;
   localparam int unsigned AW  = 64;

   logic          clk;
   logic          reset;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic          consume;
   logic [3:0]    consume_len;
   logic          inst_valid;
   logic [79:0]   inst_bytes;
   logic [AW-1:0] head_pc;
   logic          imem_error;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack;
   logic [63:0]   mem_rdata;
   logic          mem_err;

   imem_prefetch_buffer #(
      .BUF_BYTES (BUF),
      .ADDR_W    (AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .consume     (consume),
      .consume_len (consume_len),
      .inst_valid  (inst_valid),
      .inst_bytes  (inst_bytes),
      .head_pc     (head_pc),
      .imem_error  (imem_error),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .mem_err     (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: bytes fetch should see, in order, from m_head.
   logic [7:0]  q[$];
   logic [63:0] m_head;
   logic [63:0] m_next;
   logic [2:0]  m_skip;
   bit          m_err;
   bit          m_stale;

   // Memory responder and stimulus policy.
   bit          req_seen;
   int unsigned wait_cnt;
   logic [63:0] held_addr;
   int unsigned lat_lo, lat_hi;
   bit          err_en;
   logic [63:0] err_addr;
   int unsigned cons_prob;
   int unsigned force_len;
   bit          pend_redir;
   logic [63:0] pend_pc;
   bit          s_req, s_ack, s_err;
   logic [63:0] s_addr;

   function automatic logic [7:0] mbyte(input logic [63:0] a);
      return a[7:0] ^ a[15:8] ^ a[63:56];
   endfunction

   function automatic logic [63:0] mword(input logic [63:0] a);
      logic [63:0] w;
      for (int unsigned k = 0; k < 8; k++) w[8*k +: 8] = mbyte(a + 64'(k));
      return w;
   endfunction

   function automatic bit exp_imem_error();
      return m_err && (q.size() < MAX_INST_BYTES);
   endfunction

   function automatic bit exp_valid();
      return (q.size() >= MAX_INST_BYTES) || exp_imem_error();
   endfunction

   task automatic check_outputs();
      int unsigned n;
      logic [79:0] win;
      n = q.size();
      check_eq("inst_valid", 80'(inst_valid), 80'(exp_valid()));
      check_eq("imem_error", 80'(imem_error), 80'(exp_imem_error()));
      check_eq("head_pc", 80'(head_pc), 80'(m_head));
      if (n >= MAX_INST_BYTES) begin
         win = '0;
         for (int unsigned i = 0; i < MAX_INST_BYTES; i++) win[8*i +: 8] = q[i];
         check_eq("inst_bytes", inst_bytes, win);
      end
      if (mem_req) begin
         check_eq("mem_align", 80'(mem_addr[2:0]), 80'(3'd0));
         if (!m_stale)
            check_eq("no_overrun", 80'(mem_req), 80'(n + 8 - 32'(m_skip) <= BUF));
         if (req_seen) check_eq("addr_hold", 80'(mem_addr), 80'(held_addr));
      end
   endtask

   task automatic tick();
      int unsigned n;
      bit ev, eie, legal;
      @(negedge clk);
      check_outputs();
      s_req     = mem_req;
      s_addr    = mem_addr;
      mem_ack   = 1'b0;
      mem_err   = 1'b0;
      mem_rdata = '0;
      if (mem_req) begin
         if (!req_seen) begin
            req_seen  = 1'b1;
            held_addr = mem_addr;
            wait_cnt  = $urandom_range(lat_hi, lat_lo);
         end
         if (wait_cnt == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mword(mem_addr);
            mem_err   = err_en && (mem_addr == err_addr);
            req_seen  = 1'b0;
         end else begin
            wait_cnt--;
         end
      end
      consume     = 1'b0;
      consume_len = 4'd1;
      if (force_len != 0) begin
         consume     = 1'b1;
         consume_len = 4'(force_len);
         force_len   = 0;
      end else if ($urandom_range(99, 0) < cons_prob) begin
         consume     = 1'b1;
         consume_len = 4'($urandom_range(10, 1));
      end
      redirect    = pend_redir;
      redirect_pc = pend_pc;
      pend_redir  = 1'b0;
      s_ack       = mem_ack;
      s_err       = mem_err;
      @(posedge clk);
      n   = q.size();
      ev  = exp_valid();
      eie = exp_imem_error();
      if (redirect) begin
         q.delete();
         m_head  = redirect_pc;
         m_next  = {redirect_pc[63:3], 3'b000};
         m_skip  = redirect_pc[2:0];
         m_err   = 1'b0;
         m_stale = s_req && !s_ack;
      end else begin
         legal = consume && ev && !eie && (consume_len >= 1) && (32'(consume_len) <= n);
         if (legal) begin
            for (int unsigned i = 0; i < 32'(consume_len); i++) void'(q.pop_front());
            m_head = m_head + 64'(consume_len);
         end
         if (s_ack) begin
            if (m_stale) begin
               m_stale = 1'b0;
            end else begin
               check_eq("fetch_addr", 80'(s_addr), 80'(m_next));
               if (s_err) begin
                  m_err = 1'b1;
               end else begin
                  for (int unsigned k = 32'(m_skip); k < 8; k++) q.push_back(mbyte(m_next + 64'(k)));
                  m_next = m_next + 64'd8;
                  m_skip = '0;
               end
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_inst_valid"}, 80'(inst_valid), 80'(0));
      check_eq({tag, "_inst_bytes"}, inst_bytes, 80'(0));
      check_eq({tag, "_head_pc"},    80'(head_pc), 80'(0));
      check_eq({tag, "_imem_error"}, 80'(imem_error), 80'(0));
      check_eq({tag, "_mem_req"},    80'(mem_req), 80'(0));
      check_eq({tag, "_mem_addr"},   80'(mem_addr), 80'(0));
   endtask

   task automatic clear_model();
      q.delete();
      m_head = '0; m_next = '0; m_skip = '0; m_err = 1'b0; m_stale = 1'b0;
      req_seen = 1'b0; wait_cnt = 0; force_len = 0; pend_redir = 1'b0;
      mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      consume = 1'b0; consume_len = 4'd1; redirect = 1'b0; redirect_pc = '0;
   endtask

   task automatic wait_valid(input string tag);
      int unsigned k;
      k = 0;
      while (!inst_valid && k < 100) begin
         tick(); #1; k++;
      end
      check_eq(tag, 80'(inst_valid), 80'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned k;
      lat_lo = 0; lat_hi = 0; err_en = 1'b0; err_addr = '0; cons_prob = 0;
      pend_pc = '0;
      clear_model();
      reset = 1'b1;
      #3;
      check_reset_outputs("rst0");
      #19 reset = 1'b0;

      // Sequential words, immediate ack, no consume.
      wait_valid("first_valid");
      check_eq("first_bytes", inst_bytes, 80'h09080706050403020100);
      check_eq("first_head", 80'(head_pc), 80'(0));

      // rrmovq, irmovq, jXX.
      force_len = 32'(inst_length(I_RRMOVQ)); tick(); #1;
      check_eq("head_rrmovq", 80'(head_pc), 80'(2));
      repeat (6) tick();
      wait_valid("valid_irmovq");
      force_len = 32'(inst_length(I_IRMOVQ)); tick(); #1;
      check_eq("head_irmovq", 80'(head_pc), 80'(12));
      repeat (6) tick();
      wait_valid("valid_jxx");
      force_len = 32'(inst_length(I_JXX)); tick(); #1;
      check_eq("head_jxx", 80'(head_pc), 80'(21));

      // Random traffic: consumes, redirects (including near address wrap),
      // variable latency, error on one word.
      cons_prob = 60; lat_lo = 0; lat_hi = 3; err_en = 1'b1; err_addr = 64'h40;
      repeat (600) begin
         if ($urandom_range(99, 0) < 3) begin
            pend_redir = 1'b1;
            if ($urandom_range(9, 0) < 7) pend_pc = 64'($urandom_range(255, 0));
            else pend_pc = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(31, 0));
         end
         tick();
      end

      // Redirect while a request is awaiting its ack.
      cons_prob = 0; err_en = 1'b0; lat_lo = 3; lat_hi = 3;
      k = 0;
      while (mem_req && k < 20) begin tick(); #1; k++; end
      pend_redir = 1'b1; pend_pc = 64'h10; tick(); #1;
      k = 0;
      while (!mem_req && k < 20) begin tick(); #1; k++; end
      check_eq("stale_req_addr", 80'(mem_addr), 80'(64'h10));
      tick();
      pend_redir = 1'b1; pend_pc = 64'h1D; tick();
      wait_valid("valid_after_drop");
      check_eq("drop_first_byte", 80'(inst_bytes[7:0]), 80'(8'h1D));
      check_eq("drop_head", 80'(head_pc), 80'(64'h1D));

      // Back-pressure: no consume.
      lat_lo = 0; lat_hi = 3;
      repeat (40) tick();
      #1;
      check_eq("bp_mem_req", 80'(mem_req), 80'(0));
      check_eq("bp_valid", 80'(inst_valid), 80'(1));

      // Error on the word at 0x20.
      err_en = 1'b1; err_addr = 64'h20; lat_lo = 0; lat_hi = 0;
      pend_redir = 1'b1; pend_pc = 64'h0; tick();
      repeat (20) tick();
      cons_prob = 100;
      k = 0;
      while (!(m_err && q.size() < MAX_INST_BYTES) && k < 200) begin tick(); k++; end
      cons_prob = 0;
      tick(); #1;
      check_eq("err_imem_error", 80'(imem_error), 80'(1));
      check_eq("err_valid", 80'(inst_valid), 80'(1));
      err_en = 1'b0;
      pend_redir = 1'b1; pend_pc = 64'h0; tick(); #1;
      check_eq("err_cleared", 80'(imem_error), 80'(0));
      wait_valid("valid_refetch");
      check_eq("refetch_bytes", inst_bytes, 80'h09080706050403020100);

      // Asynchronous reset while a request is outstanding.
      lat_lo = 3; lat_hi = 3; cons_prob = 40;
      k = 0;
      while (!mem_req && k < 20) begin tick(); #1; k++; end
      cons_prob = 0;
      #1;
      reset = 1'b1;
      clear_model();
      #1;
      check_reset_outputs("rst_mid");
      #19 reset = 1'b0;
      lat_lo = 0; lat_hi = 1;
      wait_valid("valid_after_reset");
      check_eq("rst_bytes", inst_bytes, 80'h09080706050403020100);
      check_eq("rst_head", 80'(head_pc), 80'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
